// File: rtl/sram_read_port_if.sv
// Request/response bundle between the core load path and the SRAM read port.
// valid/ready: a transfer happens on a rising edge where both are high; the sender holds its payload stable while valid is high and ready is low.
interface sram_read_port_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              req_valid;
  logic              req_ready;
  logic [ADDR_W-1:0] req_addr;
  logic              rvalid;
  logic              rready;
  logic [WIDTH-1:0]  rdata;
  logic              rerr;

  modport master (
    output req_valid, req_addr, rready,
    input  req_ready, rvalid, rdata, rerr
  );

  modport slave (
    input  req_valid, req_addr, rready,
    output req_ready, rvalid, rdata, rerr
  );
endinterface

// File: rtl/sram_read_port.sv
// Read-side controller for the bit-cell SRAM array: precharge, raise one wordline,
// sense the differential bitlines and return a registered word plus error flag.
module sram_read_port #(
  parameter int WIDTH   = 32,
  parameter int ROWS    = 16,
  parameter int ADDR_W  = 4,
  parameter int PRE_CYC = 1,
  parameter int ACC_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  sram_read_port_if.slave  bus,
  output logic             pre_en,
  output logic [ROWS-1:0]  wl,
  output logic             sense_en,
  input  logic [WIDTH-1:0] bl,
  input  logic [WIDTH-1:0] blb,
  output logic [2:0]       dbg_state
);

  localparam int CNT_MAX = (PRE_CYC > ACC_CYC) ? PRE_CYC : ACC_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [ADDR_W:0] ROWS_W = (ADDR_W+1)'(ROWS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRECHARGE,
    S_ACCESS,
    S_SENSE,
    S_DONE
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              oor_q, oor_d;
  logic              pre_en_q, pre_en_d;
  logic [ROWS-1:0]   wl_q, wl_d;
  logic              sense_en_q, sense_en_d;
  logic              rvalid_q, rvalid_d;
  logic [WIDTH-1:0]  rdata_q, rdata_d;
  logic              rerr_q, rerr_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      addr_q     <= '0;
      oor_q      <= 1'b0;
      pre_en_q   <= 1'b0;
      wl_q       <= '0;
      sense_en_q <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rerr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      oor_q      <= oor_d;
      pre_en_q   <= pre_en_d;
      wl_q       <= wl_d;
      sense_en_q <= sense_en_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rerr_q     <= rerr_d;
    end
  end

  // Next state, counter and captured request/response.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    oor_d   = oor_q;
    rdata_d = rdata_q;
    rerr_d  = rerr_q;
    unique case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          oor_d   = ({1'b0, bus.req_addr} >= ROWS_W);
          cnt_d   = CNT_W'(PRE_CYC);
          state_d = S_PRECHARGE;
        end
      end
      S_PRECHARGE: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = CNT_W'(ACC_CYC);
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_ACCESS: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SENSE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SENSE: begin
        // Equal true/complement levels mean the cell did not develop a differential.
        if (oor_q) begin
          rdata_d = '0;
          rerr_d  = 1'b1;
        end else begin
          rdata_d = bl & ~blb;
          rerr_d  = |(~(bl ^ blb));
        end
        state_d = S_DONE;
      end
      S_DONE: begin
        if (bus.rready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Array controls are decoded from the next state so they register alongside it.
  always_comb begin
    pre_en_d   = (state_d == S_PRECHARGE);
    sense_en_d = (state_d == S_SENSE);
    rvalid_d   = (state_d == S_DONE);
    wl_d       = '0;
    if ((state_d == S_ACCESS || state_d == S_SENSE) && !oor_d) begin
      for (int r = 0; r < ROWS; r++) begin
        wl_d[r] = (addr_d == ADDR_W'(r));
      end
    end
  end

  assign bus.req_ready = (state_q == S_IDLE);
  assign bus.rvalid    = rvalid_q;
  assign bus.rdata     = rdata_q;
  assign bus.rerr      = rerr_q;
  assign pre_en        = pre_en_q;
  assign wl            = wl_q;
  assign sense_en      = sense_en_q;
  assign dbg_state     = state_q;

endmodule
